// File: rtl/video_dram_arb_pkg.sv
// Shared encodings for the video/CPU/DMA DRAM slot arbiter: owner codes,
// video bandwidth codes and the default slot-phase width.
package video_dram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_VID  = 2'b01,
    OWN_CPU  = 2'b10,
    OWN_DMA  = 2'b11
  } owner_e;

  typedef enum logic [1:0] {
    BW_NONE = 2'b00,
    BW_1_8  = 2'b01,
    BW_1_4  = 2'b10,
    BW_1_2  = 2'b11
  } video_bw_e;

  localparam int PHASE_W_DEF = 3;

  // One-hot {dma, cpu, vid} view of an owner, used for the next/strobe pulses.
  function automatic logic [2:0] owner_onehot(input owner_e o);
    case (o)
      OWN_VID: owner_onehot = 3'b001;
      OWN_CPU: owner_onehot = 3'b010;
      OWN_DMA: owner_onehot = 3'b100;
      default: owner_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/video_dram_arb_if.sv
// Memory-port bundle between the slot timing/requesters and the DRAM arbiter.
// master: timing source and requesters; slave: the arbiter.
interface video_dram_arb_if;
  logic       pre_cend;
  logic       cend;
  logic       video_go;
  logic [1:0] video_bw;
  logic       video_next;
  logic       video_strobe;
  logic       cpu_req;
  logic       cpu_next;
  logic       cpu_strobe;
  logic       dma_req;
  logic       dma_next;
  logic       dma_strobe;
  logic       dram_req;
  logic [1:0] owner;

  modport master (
    output pre_cend, cend, video_go, video_bw, cpu_req, dma_req,
    input  video_next, video_strobe, cpu_next, cpu_strobe,
           dma_next, dma_strobe, dram_req, owner
  );

  modport slave (
    input  pre_cend, cend, video_go, video_bw, cpu_req, dma_req,
    output video_next, video_strobe, cpu_next, cpu_strobe,
           dma_next, dma_strobe, dram_req, owner
  );
endinterface

// File: rtl/video_dram_arb_phase.sv
// Slot phase counter inside a video fetch burst and the decode of whether the
// upcoming slot (the phase value taken at the next cend) belongs to video.
module video_dram_arb_phase
  import video_dram_arb_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cend,
  input  logic       video_go,
  input  logic [1:0] video_bw,
  output logic       vid_slot
);

  logic [PHASE_W-1:0] phase_q, phase_d, phase_nxt;

  always_comb begin
    phase_nxt = video_go ? phase_q + 1'b1 : '0;
    phase_d   = cend ? phase_nxt : phase_q;
    vid_slot  = 1'b0;
    case (video_bw)
      BW_1_8:  vid_slot = (phase_nxt == PHASE_W'(7));
      BW_1_4:  vid_slot = (phase_nxt[1:0] == 2'b11);
      BW_1_2:  vid_slot = phase_nxt[0];
      default: vid_slot = 1'b0;
    endcase
    vid_slot = vid_slot & video_go;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

endmodule

// File: rtl/video_dram_arb.sv
// Per-slot DRAM arbiter: video gets bandwidth-dependent slots, leftovers go to
// CPU then DMA. Optional DMA anti-starvation via `VIDEO_DRAM_ARB_FAIR_EN.
module video_dram_arb
  import video_dram_arb_pkg::*;
#(
  parameter int DMA_STARVE_LIM = 4,
  parameter int PHASE_W        = PHASE_W_DEF
) (
  input logic              clk,
  input logic              rst,
  video_dram_arb_if.slave  bus
);

  if (DMA_STARVE_LIM < 1 || PHASE_W < 3) begin : g_param_check
    $error("video_dram_arb: DMA_STARVE_LIM must be >= 1 and PHASE_W >= 3");
  end

  owner_e     owner_q, owner_d, nxt_q, nxt_d, nxt_c;
  logic       armed_q, armed_d;
  logic       dram_req_q, dram_req_d;
  logic [2:0] next_q, next_d, strobe_q, strobe_d;
  logic       vid_slot;
  logic       dma_first;

  video_dram_arb_phase #(.PHASE_W(PHASE_W)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .cend     (bus.cend),
    .video_go (bus.video_go),
    .video_bw (bus.video_bw),
    .vid_slot (vid_slot)
  );

  // Owner decision; the owner of the slot ending now is never re-granted.
  always_comb begin
    nxt_c = OWN_IDLE;
    if (vid_slot)                                         nxt_c = OWN_VID;
    else if (dma_first && bus.dma_req && owner_q != OWN_DMA) nxt_c = OWN_DMA;
    else if (bus.cpu_req && owner_q != OWN_CPU)           nxt_c = OWN_CPU;
    else if (bus.dma_req && owner_q != OWN_DMA)           nxt_c = OWN_DMA;
  end

  // A decision is only honoured by a cend on the very next clock.
  always_comb begin
    nxt_d    = bus.pre_cend ? nxt_c : nxt_q;
    armed_d  = bus.pre_cend;
    owner_d  = owner_q;
    next_d   = '0;
    strobe_d = '0;
    if (bus.cend) begin
      owner_d  = armed_q ? nxt_q : OWN_IDLE;
      next_d   = owner_onehot(owner_d);
      strobe_d = owner_onehot(owner_q);
    end
    dram_req_d = (owner_d != OWN_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_IDLE;
      nxt_q      <= OWN_IDLE;
      armed_q    <= 1'b0;
      dram_req_q <= 1'b0;
      next_q     <= '0;
      strobe_q   <= '0;
    end else begin
      owner_q    <= owner_d;
      nxt_q      <= nxt_d;
      armed_q    <= armed_d;
      dram_req_q <= dram_req_d;
      next_q     <= next_d;
      strobe_q   <= strobe_d;
    end
  end

`ifdef VIDEO_DRAM_ARB_FAIR_EN
  localparam int STARVE_W = $clog2(DMA_STARVE_LIM + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign dma_first = (starve_q >= STARVE_W'(DMA_STARVE_LIM));

  // Counts non-video slots DMA asked for but lost; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!bus.dma_req) begin
      starve_d = '0;
    end else if (bus.pre_cend && !vid_slot) begin
      if (nxt_c == OWN_DMA)  starve_d = '0;
      else if (!dma_first)   starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign dma_first = 1'b0;
`endif

  assign bus.video_next   = next_q[0];
  assign bus.cpu_next     = next_q[1];
  assign bus.dma_next     = next_q[2];
  assign bus.video_strobe = strobe_q[0];
  assign bus.cpu_strobe   = strobe_q[1];
  assign bus.dma_strobe   = strobe_q[2];
  assign bus.dram_req     = dram_req_q;
  assign bus.owner        = owner_q;

endmodule
